// File: rtl/ram_copy_pkg.sv
// ram_copy_pkg: shared constants, types and helpers for the RAM copy engine.
package ram_copy_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W:0]   len_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A copy must run backwards when the destination starts inside the source
  // window (0 < dst-src < len, modulo the address space); otherwise the
  // early writes would clobber source words that have not been read yet.
  function automatic logic is_descending(input addr_t src, input addr_t dst,
                                         input len_t len);
    addr_t diff;
    diff = dst - src;
    return (diff != '0) && ({1'b0, diff} < len);
  endfunction

endpackage

// File: rtl/ram_copy_if.sv
// ram_copy_if: control handshake plus ram16k port of the copy engine.
// The checksum signal exists only when RAM_COPY_CHECKSUM_EN is defined.
interface ram_copy_if;
  import ram_copy_pkg::*;

  logic  start;
  addr_t src_addr;
  addr_t dst_addr;
  len_t  length;
  logic  busy;
  logic  done;
  logic  mem_load;
  addr_t mem_address;
  word_t mem_wdata;
  word_t mem_rdata;
`ifdef RAM_COPY_CHECKSUM_EN
  word_t checksum;
`endif

  // Engine side.
  modport master (
    input  start, src_addr, dst_addr, length, mem_rdata,
    output busy, done, mem_load, mem_address, mem_wdata
`ifdef RAM_COPY_CHECKSUM_EN
    , output checksum
`endif
  );

  // Controller / memory side.
  modport slave (
    output start, src_addr, dst_addr, length, mem_rdata,
    input  busy, done, mem_load, mem_address, mem_wdata
`ifdef RAM_COPY_CHECKSUM_EN
    , input checksum
`endif
  );

endinterface

// File: rtl/ram_copy_addr_gen.sv
// ram_copy_addr_gen: source/destination pointer pair that walks up or down
// with wrap-around, plus the count of words still to be copied.
module ram_copy_addr_gen
  import ram_copy_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  addr_t src_init,
  input  addr_t dst_init,
  input  len_t  len_init,
  input  logic  desc,
  input  logic  step,
  output addr_t src_ptr,
  output addr_t dst_ptr,
  output addr_t src_ptr_nxt,
  output logic  last
);

  addr_t src_r;
  addr_t dst_r;
  len_t  rem_r;
  logic  desc_r;
  addr_t src_step_s;
  addr_t dst_step_s;

  // Next pointer values; natural modulo arithmetic gives the wrap-around.
  always_comb begin
    src_step_s = src_r;
    dst_step_s = dst_r;
    if (desc_r) begin
      src_step_s = src_r - addr_t'(1'b1);
      dst_step_s = dst_r - addr_t'(1'b1);
    end else begin
      src_step_s = src_r + addr_t'(1'b1);
      dst_step_s = dst_r + addr_t'(1'b1);
    end
  end

  // Pointer and remaining-count registers: load at start, step per written word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_r  <= '0;
      dst_r  <= '0;
      rem_r  <= '0;
      desc_r <= 1'b0;
    end else if (load) begin
      src_r  <= src_init;
      dst_r  <= dst_init;
      rem_r  <= len_init;
      desc_r <= desc;
    end else if (step) begin
      src_r  <= src_step_s;
      dst_r  <= dst_step_s;
      rem_r  <= rem_r - len_t'(1'b1);
    end else begin
      src_r  <= src_r;
      dst_r  <= dst_r;
      rem_r  <= rem_r;
      desc_r <= desc_r;
    end
  end

  assign src_ptr     = src_r;
  assign dst_ptr     = dst_r;
  assign src_ptr_nxt = src_step_s;
  // Remaining count reaches zero on the current step.
  assign last        = (rem_r == len_t'(1'b1));

endmodule

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: copies a block of words inside ram16k, two cycles per
// word (READ then WRITE), picking the direction that keeps overlapping
// copies exact. All bus outputs are registered; they are computed from the
// next state so that each output is valid for the whole cycle of that state.
// Optional build macro: RAM_COPY_CHECKSUM_EN adds a running checksum output.
module ram_copy_engine
  import ram_copy_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  ram_copy_if.master bus
);

  state_t state_r;
  state_t state_nxt_s;

  logic  busy_r;
  logic  done_r;
  logic  load_r;
  addr_t addr_r;
  word_t wdata_r;
  addr_t addr_nxt_s;
  word_t wdata_nxt_s;

  logic  desc_s;
  addr_t len_m1_s;
  addr_t src_first_s;
  addr_t dst_first_s;
  logic  accept_s;
  logic  ptr_load_s;
  logic  ptr_step_s;

  addr_t src_ptr_s;
  addr_t dst_ptr_s;
  addr_t src_ptr_nxt_s;
  logic  last_s;

  // Starting pointers: the last word of each window when copying backwards.
  always_comb begin
    desc_s      = is_descending(bus.src_addr, bus.dst_addr, bus.length);
    len_m1_s    = addr_t'(bus.length - len_t'(1'b1));
    src_first_s = bus.src_addr;
    dst_first_s = bus.dst_addr;
    if (desc_s) begin
      src_first_s = bus.src_addr + len_m1_s;
      dst_first_s = bus.dst_addr + len_m1_s;
    end else begin
      src_first_s = bus.src_addr;
      dst_first_s = bus.dst_addr;
    end
  end

  assign accept_s   = (state_r == IDLE) && bus.start;
  assign ptr_load_s = accept_s && (bus.length != '0);
  assign ptr_step_s = (state_r == WRITE);

  ram_copy_addr_gen u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (ptr_load_s),
    .src_init    (src_first_s),
    .dst_init    (dst_first_s),
    .len_init    (bus.length),
    .desc        (desc_s),
    .step        (ptr_step_s),
    .src_ptr     (src_ptr_s),
    .dst_ptr     (dst_ptr_s),
    .src_ptr_nxt (src_ptr_nxt_s),
    .last        (last_s)
  );

  // Next state plus the address/data the bus must show in that next state.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = '0;
    wdata_nxt_s = '0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = READ;
            addr_nxt_s  = src_first_s;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        state_nxt_s = WRITE;
        addr_nxt_s  = dst_ptr_s;
        wdata_nxt_s = bus.mem_rdata;
      end
      WRITE: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = READ;
          addr_nxt_s  = src_ptr_nxt_s;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered bus outputs; reset clears them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      load_r  <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
      load_r  <= (state_nxt_s == WRITE);
      addr_r  <= addr_nxt_s;
      wdata_r <= wdata_nxt_s;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.mem_load    = load_r;
  assign bus.mem_address = addr_r;
  assign bus.mem_wdata   = wdata_r;

`ifdef RAM_COPY_CHECKSUM_EN
  word_t checksum_r;

  // Running mod-2^16 sum of the words written by the current copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_r <= '0;
    end else if (accept_s) begin
      checksum_r <= '0;
    end else if (state_r == WRITE) begin
      checksum_r <= checksum_r + wdata_r;
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign bus.checksum = checksum_r;
`endif

endmodule
